control_unit: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 23 ++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: the instruction decode carried from data_path to control_unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit.sv
// K&S multi-cycle sequencer: fetch/decode/execute FSM driving data_path and RAM strobes,
// plus a saturating retired-instruction counter.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    reg_zero,
  input  logic                    reg_neg,
  input  logic                    reg_ov,
  input  logic                    reg_sov,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        retired_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_LATCH_IR, S_DECODE, S_LOAD_ADDR, S_LOAD_WB,
    S_STORE, S_ALU, S_BRANCH, S_NOP, S_HALT
  } state_t;

  state_t state, state_next;

  // Signed overflow is registered in data_path but no branch condition consumes it.
  logic unused_sov;
  assign unused_sov = reg_sov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_count <= '0;
    else if (pc_enable && (retired_count != '1))
      retired_count <= retired_count + 1'b1;
  end

  always_comb begin
    state_next       = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;

    case (state)
      S_FETCH: state_next = S_LATCH_IR;

      S_LATCH_IR: begin
        ir_enable  = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:  state_next = S_LOAD_ADDR;
          I_STORE: state_next = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE:
                   state_next = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                   state_next = S_BRANCH;
          I_HALT:  state_next = S_HALT;
          default: state_next = S_NOP;
        endcase
      end

      // Address held across both cycles so data_in is valid during write-back.
      S_LOAD_ADDR: begin
        addr_sel   = 1'b1;
        state_next = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
      end

      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
      end

      S_ALU: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
        case (decoded_instruction)
          I_ADD: begin operation = 2'b01; flags_reg_enable = 1'b1; end
          I_SUB: begin operation = 2'b10; flags_reg_enable = 1'b1; end
          I_AND: begin operation = 2'b11; flags_reg_enable = 1'b1; end
          I_OR:  begin operation = 2'b00; flags_reg_enable = 1'b1; end
          default: operation = 2'b00;  // MOVE: source OR'd with itself, flags untouched
        endcase
      end

      S_BRANCH: begin
        pc_enable  = 1'b1;
        state_next = S_FETCH;
        case (decoded_instruction)
          I_BRANCH: branch = 1'b1;
          I_BZERO:  branch = reg_zero;
          I_BNZERO: branch = ~reg_zero;
          I_BNEG:   branch = reg_neg;
          I_BNNEG:  branch = ~reg_neg;
          I_BOV:    branch = reg_ov;
          I_BNOV:   branch = ~reg_ov;
          default:  branch = 1'b0;
        endcase
      end

      S_NOP: begin
        pc_enable  = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: begin
        halt       = 1'b1;
        state_next = S_HALT;
      end

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-cycle output vectors for each instruction class.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decoded_instruction_type instr = I_NOP;
  logic z = 1'b0, n = 1'b0, ov = 1'b0, sov = 1'b0;

  logic br, pc, ir, as, cs, wr, fl, rw, hlt;
  logic [1:0] op;
  logic [15:0] cnt;

  logic br3, pc3, ir3, as3, cs3, wr3, fl3, rw3, hlt3;
  logic [1:0] op3;
  logic [2:0] cnt3;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
    .reg_zero(z), .reg_neg(n), .reg_ov(ov), .reg_sov(sov),
    .branch(br), .pc_enable(pc), .ir_enable(ir), .addr_sel(as), .c_sel(cs),
    .operation(op), .write_reg_enable(wr), .flags_reg_enable(fl),
    .ram_write_enable(rw), .halt(hlt), .retired_count(cnt)
  );

  control_unit #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
    .reg_zero(z), .reg_neg(n), .reg_ov(ov), .reg_sov(sov),
    .branch(br3), .pc_enable(pc3), .ir_enable(ir3), .addr_sel(as3), .c_sel(cs3),
    .operation(op3), .write_reg_enable(wr3), .flags_reg_enable(fl3),
    .ram_write_enable(rw3), .halt(hlt3), .retired_count(cnt3)
  );

  // Field order: branch pc_enable ir_enable addr_sel c_sel operation[1:0] write_reg flags ram_write halt
  logic [10:0] outs;
  assign outs = {br, pc, ir, as, cs, op, wr, fl, rw, hlt};

  localparam logic [10:0] V_ZERO  = 11'b00000000000;
  localparam logic [10:0] V_LATCH = 11'b00100000000;
  localparam logic [10:0] V_PC    = 11'b01000000000;
  localparam logic [10:0] V_TAKEN = 11'b11000000000;
  localparam logic [10:0] V_LADDR = 11'b00010000000;
  localparam logic [10:0] V_LWB   = 11'b01010001000;
  localparam logic [10:0] V_STORE = 11'b01010000010;
  localparam logic [10:0] V_ADD   = 11'b01001011100;
  localparam logic [10:0] V_SUB   = 11'b01001101100;
  localparam logic [10:0] V_MOVE  = 11'b01001001000;
  localparam logic [10:0] V_HALT  = 11'b00000000001;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_cnt = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] seq [4];
    seq = '{V_LATCH, V_ZERO, V_PC, V_ZERO};
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== V_ZERO) $display("FAIL reset_outs: got %b expected %b", outs, V_ZERO);
    else passed++;
    checks++;
    if (cnt !== 16'd0) $display("FAIL reset_count: got %0d expected 0", cnt);
    else passed++;
    rst_n = 1'b1;
    checks++;
    if (outs !== V_ZERO) $display("FAIL reset_fetch: got %b expected %b", outs, V_ZERO);
    else passed++;
    foreach (seq[i]) begin
      tick();
      checks++;
      if (outs !== seq[i]) $display("FAIL nop_cycle%0d: got %b expected %b", i + 2, outs, seq[i]);
      else passed++;
      if (i == 2) begin
        checks++;
        if (cnt !== 16'd0) $display("FAIL nop_count_before: got %0d expected 0", cnt);
        else passed++;
      end
    end
    exp_cnt = 16'd1;
    checks++;
    if (cnt !== exp_cnt) $display("FAIL nop_count_after: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_load();
    logic [10:0] seq [6];
    seq = '{V_LATCH, V_ZERO, V_LADDR, V_LWB, V_ZERO, V_LATCH};
    instr = I_LOAD;
    foreach (seq[i]) begin
      tick();
      if (i == 4) begin
        instr = I_NOP;
        exp_cnt++;
      end
      checks++;
      if (outs !== seq[i]) $display("FAIL load_cycle%0d: got %b expected %b", i + 2, outs, seq[i]);
      else passed++;
    end
    repeat (3) tick();
    exp_cnt++;
    checks++;
    if (cnt !== exp_cnt) $display("FAIL load_count: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_alu();
    decoded_instruction_type ins [3];
    logic [10:0] ev [3];
    ins = '{I_SUB, I_MOVE, I_ADD};
    ev  = '{V_SUB, V_MOVE, V_ADD};
    foreach (ins[i]) begin
      instr = ins[i];
      repeat (3) tick();
      checks++;
      if (outs !== ev[i]) $display("FAIL alu_%s: got %b expected %b", ins[i].name(), outs, ev[i]);
      else passed++;
      tick();
      exp_cnt++;
    end
    checks++;
    if (cnt !== exp_cnt) $display("FAIL alu_count: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_store();
    instr = I_STORE;
    repeat (3) tick();
    checks++;
    if (outs !== V_STORE) $display("FAIL store_exec: got %b expected %b", outs, V_STORE);
    else passed++;
    tick();
    exp_cnt++;
    checks++;
    if (outs !== V_ZERO) $display("FAIL store_fetch: got %b expected %b", outs, V_ZERO);
    else passed++;
  endtask

  task automatic test_branch();
    decoded_instruction_type ins [8];
    logic [2:0] flg [8];   // {zero, neg, ov}
    logic taken [8];
    ins   = '{I_BZERO, I_BZERO, I_BNOV, I_BRANCH, I_BNEG, I_BNNEG, I_BOV, I_BNZERO};
    flg   = '{3'b100,  3'b000,  3'b000, 3'b000,   3'b010, 3'b010,  3'b001, 3'b000};
    taken = '{1'b1,    1'b0,    1'b1,   1'b1,     1'b1,   1'b0,    1'b1,   1'b1};
    foreach (ins[i]) begin
      instr = ins[i];
      {z, n, ov} = flg[i];
      repeat (3) tick();
      checks++;
      if (outs !== (taken[i] ? V_TAKEN : V_PC))
        $display("FAIL branch_%0d_%s: got %b expected %b", i, ins[i].name(), outs,
                 taken[i] ? V_TAKEN : V_PC);
      else passed++;
      tick();
      exp_cnt++;
    end
    checks++;
    if (cnt !== exp_cnt) $display("FAIL branch_count: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_halt();
    int bad = 0;
    instr = I_HALT;
    repeat (3) tick();
    checks++;
    if (outs !== V_HALT) $display("FAIL halt_enter: got %b expected %b", outs, V_HALT);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (outs !== V_HALT || cnt !== exp_cnt) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL halt_hold: %0d bad cycles, outs %b count %0d expected %b %0d",
                           bad, outs, cnt, V_HALT, exp_cnt);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== V_ZERO || cnt !== 16'd0)
      $display("FAIL halt_reset: got %b count %0d expected %b count 0", outs, cnt, V_ZERO);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_saturation();
    instr = I_NOP;
    repeat (9 * 4) tick();
    exp_cnt = exp_cnt + 16'd9;
    checks++;
    if (cnt3 !== 3'd7) $display("FAIL sat_count3: got %0d expected 7", cnt3);
    else passed++;
    checks++;
    if (cnt !== exp_cnt) $display("FAIL sat_count16: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
    repeat (4) tick();
    exp_cnt++;
    checks++;
    if (cnt3 !== 3'd7) $display("FAIL sat_hold3: got %0d expected 7", cnt3);
    else passed++;
    checks++;
    if (cnt !== exp_cnt) $display("FAIL sat_hold16: got %0d expected %0d", cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    instr = I_LOAD;
    repeat (4) tick();
    checks++;
    if (wr !== 1'b1) $display("FAIL mid_wb_active: got %b expected 1", wr);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr !== 1'b0 || outs !== V_ZERO)
      $display("FAIL mid_reset_drop: wr %b outs %b expected 0 %b", wr, outs, V_ZERO);
    else passed++;
    checks++;
    if (cnt !== 16'd0 || cnt3 !== 3'd0)
      $display("FAIL mid_reset_count: got %0d/%0d expected 0/0", cnt, cnt3);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    instr = I_NOP;
    repeat (4) tick();
    checks++;
    if (cnt !== 16'd1) $display("FAIL mid_resume_count: got %0d expected 1", cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_store();
    test_branch();
    test_halt();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
